// File: rtl/datapath_pkg.sv
// Types and constants shared by the instruction issue sequencer and anything
// that builds R-type programs for the datapath.
package datapath_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    ISSUE  = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  // R-type funct field values understood by the datapath
  localparam logic [5:0] ADD = 6'b001000;
  localparam logic [5:0] SUB = 6'b100011;
  localparam logic [5:0] AND = 6'b100101;
  localparam logic [5:0] OR  = 6'b100110;
  localparam logic [5:0] SLT = 6'b101010;

  // An all-zero word terminates a program and is never issued
  localparam logic [31:0] END_MARKER = 32'h0;

  function automatic logic [31:0] mk_rtype(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] funct);
    return {6'b000000, rs, rt, rd, 5'b00000, funct};
  endfunction

endpackage

// File: rtl/instr_prog_mem.sv
// Program store for the issue sequencer: synchronous write, registered read.
// Contents are deliberately not reset so a program survives rst_n.
module instr_prog_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Write-first on an address collision: a word loaded in the same cycle as
  // start must be the one fetched for address 0.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_issue_seq.sv
// Issues program-memory words to the datapath over valid/ack, then waits a
// fixed settle time and records the datapath zero flag for each word.
module instr_issue_seq
  import datapath_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 4,
  parameter int SETTLE_CYC = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_en,
  input  logic [ADDR_W-1:0]       load_addr,
  input  logic [DATA_W-1:0]       load_data,
  input  logic                    start,
  output logic [DATA_W-1:0]       instruccion_r,
  output logic                    instr_valid,
  input  logic                    instr_ack,
  input  logic                    tr_zf,
  output logic [ADDR_W-1:0]       pc,
  output logic                    busy,
  output logic                    done,
  output logic [(2**ADDR_W)-1:0]  zf_hist,
  output logic [ADDR_W:0]         zf_count
);
  localparam int                DEPTH     = 2**ADDR_W;
  localparam int                CNT_W     = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [7:0]        SETTLE_LD = 8'(SETTLE_CYC);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEPTH);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [7:0]        r_settle;
  logic [DATA_W-1:0] r_instr, w_rdata;
  logic [DEPTH-1:0]  r_zf_hist;
  logic [CNT_W-1:0]  r_zf_count;
  logic              w_start, w_mem_we, w_settle_end, w_is_marker;

  assign w_start      = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_mem_we     = load_en && (r_state == IDLE);
  assign w_settle_end = (r_state == SETTLE) && (r_settle == 8'd1);
  assign w_is_marker  = (w_rdata == DATA_W'(END_MARKER));

  // The memory is read at the next pc, so mem[pc] is already registered
  // while FETCH decides between ISSUE and DONE.
  always_comb begin
    w_pc_nxt = r_pc;
    if (w_start)
      w_pc_nxt = '0;
    else if (w_settle_end && (r_pc != LAST_ADDR))
      w_pc_nxt = r_pc + 1'b1;
  end

  instr_prog_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_mem_we),
    .i_waddr (load_addr),
    .i_wdata (load_data),
    .i_raddr (w_pc_nxt),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: if (w_start) w_state_nxt = FETCH;
      FETCH:      w_state_nxt = w_is_marker ? DONE : ISSUE;
      ISSUE:      if (instr_ack) w_state_nxt = SETTLE;
      SETTLE:     if (w_settle_end) w_state_nxt = (r_pc == LAST_ADDR) ? DONE : FETCH;
      default:    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= '0;
      r_settle   <= '0;
      r_instr    <= '0;
      r_zf_hist  <= '0;
      r_zf_count <= '0;
    end else begin
      r_pc <= w_pc_nxt;
      if (r_state == FETCH) r_instr <= w_rdata;
      if ((r_state == ISSUE) && instr_ack)
        r_settle <= SETTLE_LD;
      else if (r_state == SETTLE)
        r_settle <= r_settle - 1'b1;
      if (w_start) begin
        r_zf_hist  <= '0;
        r_zf_count <= '0;
      end else if (w_settle_end) begin
        r_zf_hist[r_pc] <= tr_zf;
        if (tr_zf && (r_zf_count != CNT_MAX)) r_zf_count <= r_zf_count + 1'b1;
      end
    end
  end

  always_comb begin
    instr_valid = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      FETCH, SETTLE: busy = 1'b1;
      ISSUE: begin
        busy        = 1'b1;
        instr_valid = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign instruccion_r = r_instr;
  assign pc            = r_pc;
  assign zf_hist       = r_zf_hist;
  assign zf_count      = r_zf_count;

endmodule

// File: tb/tb_instr_issue_seq.sv
// Directed bench for instr_issue_seq: a timing/scoreboard model of issue
// windows and zero-flag history, checked every cycle, plus literal pins.
module tb_instr_issue_seq;
  import datapath_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int SETTLE = 10;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic              load_en = 1'b0, start = 1'b0, instr_ack = 1'b0, tr_zf = 1'b0;
  logic [ADDR_W-1:0] load_addr = '0;
  logic [DATA_W-1:0] load_data = '0;
  logic [DATA_W-1:0] instruccion_r;
  logic              instr_valid, busy, done;
  logic [ADDR_W-1:0] pc;
  logic [DEPTH-1:0]  zf_hist;
  logic [ADDR_W:0]   zf_count;

  instr_issue_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SETTLE_CYC(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .instruccion_r(instruccion_r),
    .instr_valid(instr_valid), .instr_ack(instr_ack), .tr_zf(tr_zf), .pc(pc),
    .busy(busy), .done(done), .zf_hist(zf_hist), .zf_count(zf_count));

  always #5 clk = ~clk;

  int n_checks = 0, n_err = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // ---------------- stimulus-side state ----------------
  logic [DEPTH-1:0]  zf_tab = '0;
  logic              ack_tied = 1'b0;
  int                hold_idx = 99, hold_n = 1;
  int                vcnt = 0, acc_n = 0;

  // Ack driver: raise ack after the word has been valid for hold cycles
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      vcnt = 0; acc_n = 0; instr_ack = 1'b0;
    end else if (ack_tied) begin
      instr_ack = 1'b1;
    end else if (instr_valid) begin
      vcnt++;
      instr_ack = (vcnt > ((acc_n == hold_idx) ? hold_n : 1));
    end else begin
      if (vcnt > 0) acc_n++;
      vcnt = 0; instr_ack = 1'b0;
    end
  end

  // ---------------- behavioural model + compare ----------------
  logic [DATA_W-1:0] mem_m [DEPTH];
  bit                m_on = 0, m_done = 0, m_iss = 0;
  int                m_idx = 0, m_due = -1, m_done_due = -1, m_samp = -1, m_sel = 0;
  logic [DEPTH-1:0]  exp_hist = '0;
  int                exp_cnt = 0;
  logic [31:0]       acc_q[$];
  int                v_cycles[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      m_on = 0; m_done = 0; m_iss = 0; m_due = -1; m_done_due = -1; m_samp = -1;
      tr_zf = 1'b0;
      chk("rst_valid", instr_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pc", pc, 0);
      chk("rst_instr", instruccion_r, 0);
      chk("rst_hist", zf_hist, 0);
      chk("rst_count", zf_count, 0);
    end else begin
      if (cyc == m_due) begin
        if (mem_m[m_idx] == 32'h0) m_done = 1; else m_iss = 1;
      end
      if (cyc == m_done_due) m_done = 1;
      if (instr_valid) v_cycles.push_back(cyc);
      chk("valid", instr_valid, m_iss);
      chk("busy", busy, m_on && !m_done);
      chk("done", done, m_done);
      if (m_iss) begin
        chk("instr", instruccion_r, mem_m[m_idx]);
        chk("issue_pc", pc, m_idx);
      end
      if (m_done) begin
        chk("done_pc", pc, m_idx);
        chk("done_hist", zf_hist, exp_hist);
        chk("done_count", zf_count, exp_cnt);
      end
      if (m_on && !m_done && !m_iss && m_idx == 0 && cyc == m_due - 1) begin
        chk("clr_hist", zf_hist, 0);
        chk("clr_count", zf_count, 0);
      end
      // inputs for the coming edge; the flag is only correct on its sample cycle
      tr_zf = (cyc == m_samp) ? zf_tab[m_sel] : !zf_tab[m_sel];
      if (load_en && !m_on) mem_m[load_addr] = load_data;
      if (start && (!m_on || m_done)) begin
        m_on = 1; m_done = 0; m_iss = 0; m_idx = 0; m_due = cyc + 2;
        m_done_due = -1; exp_hist = '0; exp_cnt = 0;
      end else if (m_iss && instr_ack) begin
        acc_q.push_back(instruccion_r);
        m_iss = 0;
        exp_hist[m_idx] = zf_tab[m_idx];
        exp_cnt += int'(zf_tab[m_idx]);
        m_sel = m_idx;
        m_samp = cyc + SETTLE;
        if (m_idx == DEPTH - 1) m_done_due = cyc + 1 + SETTLE;
        else begin m_idx++; m_due = cyc + SETTLE + 2; end
      end
    end
  end

  // ---------------- tasks (entered and left at posedge+1) ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic load(input int a, input logic [31:0] d);
    load_en = 1'b1; load_addr = ADDR_W'(a); load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int maxc);
    for (int i = 0; i < maxc && !done; i++) begin
      @(posedge clk); #1;
    end
    if (!done) begin
      n_checks++; n_err++;
      $display("FAIL %s: timeout, done still 0 after %0d cycles", nm, maxc);
    end
  endtask

  task automatic clear_logs();
    acc_q.delete(); v_cycles.delete();
  endtask

  logic [5:0]  fn_tab [5];
  logic [31:0] prog [5];
  int          st_cyc;

  initial begin
    fn_tab = '{ADD, SUB, AND, OR, SLT};
    prog[0] = mk_rtype(5'd1, 5'd2, 5'd3, ADD);
    prog[1] = mk_rtype(5'd4, 5'd4, 5'd5, SUB);
    prog[2] = mk_rtype(5'd1, 5'd2, 5'd6, AND);
    prog[3] = mk_rtype(5'd1, 5'd2, 5'd7, OR);
    prog[4] = mk_rtype(5'd1, 5'd2, 5'd8, SLT);

    // T2: five words plus marker; mem[0] written on the start cycle
    do_reset();
    zf_tab = 16'h0002;
    for (int i = 1; i < 5; i++) load(i, prog[i]);
    load(5, 32'h0);
    clear_logs();
    load_en = 1'b1; load_addr = '0; load_data = prog[0]; start = 1'b1;
    @(posedge clk); #1;
    load_en = 1'b0; start = 1'b0;
    repeat (6) @(posedge clk); #1;
    start_pulse();                      // while busy: must be ignored
    repeat (20) @(posedge clk); #1;
    start_pulse();
    wait_done("t2_done", 300);
    chk("t2_pc", pc, 5);
    chk("t2_hist", zf_hist, 16'h0002);
    chk("t2_count", zf_count, 1);
    chk("t2_issues", acc_q.size(), 5);
    if (acc_q.size() > 1) chk("t2_word1", acc_q[1], 32'h00842823);
    chk("t2_valid_cycles", v_cycles.size(), 10);

    // T1: async reset while word 2 is waiting in ISSUE
    do_reset();
    hold_idx = 2; hold_n = 1000;
    start_pulse();
    for (int i = 0; i < 200 && !(instr_valid && pc == 2); i++) begin
      @(posedge clk); #1;
    end
    chk("t1_reached", instr_valid && pc == 2, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_valid", instr_valid, 0);
    chk("t1_pc", pc, 0);
    chk("t1_busy", busy, 0);
    chk("t1_count", zf_count, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // T3: memory survived reset; word 2 held off for 20 cycles
    hold_idx = 2; hold_n = 20;
    clear_logs();
    start_pulse();
    wait_done("t3_done", 400);
    chk("t3_issues", acc_q.size(), 5);
    if (acc_q.size() > 2) chk("t3_word2", acc_q[2], 32'h00223025);
    chk("t3_valid_cycles", v_cycles.size(), 29);
    chk("t3_hist", zf_hist, 16'h0002);
    hold_idx = 99;

    // T4: full memory, no marker, no wrap
    do_reset();
    zf_tab = 16'hFFFF;
    for (int i = 0; i < DEPTH; i++)
      load(i, mk_rtype(5'(i), 5'(i + 1), 5'(i + 2), fn_tab[i % 5]));
    clear_logs();
    start_pulse();
    wait_done("t4_done", 600);
    repeat (5) @(posedge clk); #1;
    chk("t4_pc", pc, 15);
    chk("t4_hist", zf_hist, 16'hFFFF);
    chk("t4_count", zf_count, 16);
    chk("t4_issues", acc_q.size(), 16);

    // T5: marker at address 0; loads are ignored once out of IDLE
    do_reset();
    load(0, 32'h0);
    clear_logs();
    start_pulse();
    chk("t5_busy", busy, 1);
    chk("t5_not_done", done, 0);
    @(posedge clk); #1;
    chk("t5_done", done, 1);
    chk("t5_pc", pc, 0);
    load(0, prog[0]);
    start_pulse();
    repeat (4) @(posedge clk); #1;
    chk("t5_still_done", done, 1);
    chk("t5_no_valid", v_cycles.size(), 0);

    // T6: ack tied high, marker at 3 -> valid pulses 12 cycles apart
    do_reset();
    load(0, prog[0]);
    load(3, 32'h0);
    zf_tab = 16'h0005;
    ack_tied = 1'b1;
    clear_logs();
    start_pulse();
    st_cyc = cyc;
    wait_done("t6_done", 200);
    ack_tied = 1'b0;
    chk("t6_pulses", v_cycles.size(), 3);
    if (v_cycles.size() == 3) begin
      chk("t6_first", v_cycles[0] - st_cyc, 1);
      chk("t6_gap1", v_cycles[1] - v_cycles[0], 12);
      chk("t6_gap2", v_cycles[2] - v_cycles[1], 12);
    end
    chk("t6_pc", pc, 3);
    chk("t6_hist", zf_hist, 16'h0005);
    chk("t6_count", zf_count, 2);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
